// File: rtl/async_transmitter_if.sv
// Byte-producer to UART-transmitter handshake bundle.
// The producer (master) drives TxD_start/TxD_data and observes the serial
// line and busy flag; the transmitter (slave) drives TxD and TxD_busy.
interface async_transmitter_if;
   logic       TxD_start;
   logic [7:0] TxD_data;
   logic       TxD;
   logic       TxD_busy;

   modport master (
      output TxD_start,
      output TxD_data,
      input  TxD,
      input  TxD_busy
   );

   modport slave (
      input  TxD_start,
      input  TxD_data,
      output TxD,
      output TxD_busy
   );
endinterface

// File: rtl/async_transmitter.sv
// UART transmit serializer: start bit, 8 data bits LSB first, odd parity,
// stop bit. Baud timing comes from an internal divider of CLK_FREQ/BAUD clocks.
// Optional feature macro: ASYNC_TX_TWO_STOP_EN selects two stop bits
// (default build: one stop bit).
module async_transmitter #(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 38400
) (
   input  logic                clk,
   input  logic                rst,
   async_transmitter_if.slave  bus
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUD;
   localparam int DIV_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);

`ifdef ASYNC_TX_TWO_STOP_EN
   // Second stop bit reuses the bit counter: STOP completes when it reaches 1.
   localparam logic [2:0] STOP_LAST = 3'd1;
`else
   localparam logic [2:0] STOP_LAST = 3'd0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Odd parity: data ones plus the parity bit always sum to an odd count.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   state_t           state_r, state_s;
   logic [DIV_W-1:0] div_r, div_s;
   logic [2:0]       bit_r, bit_s;
   logic [7:0]       shift_r, shift_s;
   logic             parity_r, parity_s;
   logic             txd_r, txd_s;
   logic             busy_r, busy_s;
   logic             tick_s;

   assign bus.TxD      = txd_r;
   assign bus.TxD_busy = busy_r;

   // Next-state and next-output logic; TxD/busy are computed one cycle ahead
   // so the registered outputs change exactly at bit boundaries.
   always_comb begin
      state_s  = state_r;
      div_s    = div_r;
      bit_s    = bit_r;
      shift_s  = shift_r;
      parity_s = parity_r;
      txd_s    = txd_r;
      busy_s   = busy_r;
      tick_s   = (div_r == DIV_LAST);

      if (state_r == ST_IDLE) begin
         div_s = {DIV_W{1'b0}};
      end else if (tick_s) begin
         div_s = {DIV_W{1'b0}};
      end else begin
         div_s = div_r + DIV_W'(1);
      end

      case (state_r)
         ST_IDLE: begin
            txd_s  = 1'b1;
            busy_s = 1'b0;
            bit_s  = 3'd0;
            if (bus.TxD_start) begin
               shift_s  = bus.TxD_data;
               parity_s = odd_parity(bus.TxD_data);
               txd_s    = 1'b0;
               busy_s   = 1'b1;
               state_s  = ST_START;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s) begin
               txd_s   = shift_r[0];
               shift_s = {1'b0, shift_r[7:1]};
               bit_s   = 3'd0;
               state_s = ST_DATA;
            end else begin
               state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s && (bit_r == 3'd7)) begin
               txd_s   = parity_r;
               bit_s   = 3'd0;
               state_s = ST_PARITY;
            end else if (tick_s) begin
               txd_s   = shift_r[0];
               shift_s = {1'b0, shift_r[7:1]};
               bit_s   = bit_r + 3'd1;
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (tick_s) begin
               txd_s   = 1'b1;
               state_s = ST_STOP;
            end else begin
               state_s = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (tick_s && (bit_r == STOP_LAST)) begin
               txd_s   = 1'b1;
               busy_s  = 1'b0;
               bit_s   = 3'd0;
               state_s = ST_IDLE;
            end else if (tick_s) begin
               bit_s   = bit_r + 3'd1;
            end else begin
               state_s = ST_STOP;
            end
         end
         default: begin
            txd_s   = 1'b1;
            busy_s  = 1'b0;
            bit_s   = 3'd0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset that aborts any frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         div_r    <= {DIV_W{1'b0}};
         bit_r    <= 3'd0;
         shift_r  <= 8'd0;
         parity_r <= 1'b0;
         txd_r    <= 1'b1;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         div_r    <= div_s;
         bit_r    <= bit_s;
         shift_r  <= shift_s;
         parity_r <= parity_s;
         txd_r    <= txd_s;
         busy_r   <= busy_s;
      end
   end

endmodule

// File: tb/tb_async_transmitter.sv
// Scoreboard bench for async_transmitter: bytes are queued as they are sent,
// and a line monitor decodes each frame at mid-bit and compares.
module tb_async_transmitter;
   localparam int CLK_FREQ   = 1600000;
   localparam int BAUD       = 100000;
   localparam int BC         = CLK_FREQ / BAUD;
`ifdef ASYNC_TX_TWO_STOP_EN
   localparam int STOP_BITS  = 2;
`else
   localparam int STOP_BITS  = 1;
`endif
   localparam int NBITS      = 10 + STOP_BITS;
   localparam int FRAME      = NBITS * BC;
   localparam int IDLE_GAP   = 13 * BC;

   logic clk = 1'b0;
   logic rst;
   async_transmitter_if bus ();

   async_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int        n_cmp = 0;
   int        n_bad = 0;
   int        n_pushed = 0;
   int        n_frames = 0;
   bit        mon_en = 1'b0;
   logic [7:0] sb [$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Wait (bounded) for the line to go idle, then issue one byte and queue it.
   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      while (bus.TxD_busy !== 1'b0 && n < 20 * BC) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20 * BC) check("send_wait_idle_timeout", 1, 0);
      bus.TxD_start = 1'b1;
      bus.TxD_data  = b;
      sb.push_back(b);
      n_pushed++;
      @(posedge clk); #1;
      bus.TxD_start = 1'b0;
      bus.TxD_data  = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Line monitor: detect a falling edge from idle, sample each bit at its
   // middle, measure busy duration, and compare against the queued byte.
   initial begin
      logic        prev_txd;
      logic [11:0] bits;
      logic [7:0]  exp_b;
      logic [7:0]  got_b;
      int          c;
      int          ones;
      prev_txd = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en && prev_txd === 1'b1 && bus.TxD === 1'b0) begin
            bits = 12'd0;
            c = 0;
            while (bus.TxD_busy === 1'b1 && c < 14 * BC) begin
               if ((c % BC) == (BC / 2) && (c / BC) < 12) bits[c / BC] = bus.TxD;
               c++;
               @(negedge clk);
            end
            n_frames++;
            check("frame_length", c, FRAME);
            if (sb.size() == 0) begin
               check("unexpected_frame", 1, 0);
            end else begin
               exp_b = sb.pop_front();
               got_b = bits[8:1];
               ones = 0;
               for (int i = 0; i < 8; i++) ones += int'(exp_b[i]);
               check("start_bit", int'(bits[0]), 0);
               check("data_byte", int'(got_b), int'(exp_b));
               check("parity_bit", int'(bits[9]), ((ones % 2) == 0) ? 1 : 0);
               for (int s = 0; s < STOP_BITS; s++)
                  check("stop_bit", int'(bits[10 + s]), 1);
            end
         end
         prev_txd = bus.TxD;
      end
   end

   // Global time bound.
   initial begin
      #(100000 * 10);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   // Stimulus sequence.
   initial begin
      int bad_idle;
      logic [7:0] b;
      rst = 1'b1;
      bus.TxD_start = 1'b0;
      bus.TxD_data  = 8'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("reset_txd", int'(bus.TxD), 1);
      check("reset_busy", int'(bus.TxD_busy), 0);
      bad_idle = 0;
      for (int i = 0; i < 3 * BC; i++) begin
         @(posedge clk); #1;
         if (bus.TxD !== 1'b1 || bus.TxD_busy !== 1'b0) bad_idle++;
      end
      check("idle_no_activity", bad_idle, 0);
      mon_en = 1'b1;

      // Directed bytes, including parity corner cases.
      send(8'hA5); check("busy_after_accept", int'(bus.TxD_busy), 1);
      check("txd_low_after_accept", int'(bus.TxD), 0);
      idle(IDLE_GAP);
      send(8'h00); idle(IDLE_GAP);
      send(8'hFF); idle(IDLE_GAP);
      send(8'h01); idle(IDLE_GAP);

      // Random bytes.
      for (int i = 0; i < 44; i++) begin
         send(8'($urandom));
         idle(IDLE_GAP);
      end

      // Back-to-back: second request in the first idle cycle.
      send(8'h81);
      send(8'h7E);
      idle(IDLE_GAP);

      // Request while busy must be dropped.
      send(8'hC3);
      idle(3 * BC);
      bus.TxD_start = 1'b1;
      bus.TxD_data  = 8'h3C;
      @(posedge clk); #1;
      bus.TxD_start = 1'b0;
      idle(IDLE_GAP);

      // Reset during DATA(3) aborts the frame at once.
      mon_en = 1'b0;
      send(8'hF7);
      void'(sb.pop_back());
      n_pushed--;
      idle(4 * BC + BC / 2);
      check("data3_before_reset", int'(bus.TxD), 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_txd", int'(bus.TxD), 1);
      check("abort_busy", int'(bus.TxD_busy), 0);
      rst = 1'b0;
      idle(2 * BC);
      check("idle_after_abort", int'(bus.TxD), 1);
      mon_en = 1'b1;
      idle(2);
      send(8'h55);
      idle(FRAME + 4 * BC);

      check("frames_decoded", n_frames, n_pushed);
      check("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/async_transmitter.md
Name: async_transmitter

Overview:
UART transmit serializer. Accepts one byte per TxD_start pulse and shifts it out on TxD, LSB first, with an odd parity bit. The frame is start, 8 data bits, parity, then stop. Sits between a byte producer and the board serial TX pin, in a single clock domain. Baud timing comes from an internal clock divider.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz (10 ns period).
BAUD, 38400, serial bit rate in bits/s.
BIT_CYCLES, CLK_FREQ/BAUD (integer division; 2604 at defaults), clocks per serial bit; derived, not overridden separately.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
TxD_start  input  1  single-cycle request to send TxD_data; honoured only when TxD_busy=0.
TxD_data  input  8  byte to transmit; sampled in the accepting cycle only.
TxD  output  1  serial line; idles high.
TxD_busy  output  1  high while a frame is in progress.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset (rst=1 at a clk edge): TxD=1, TxD_busy=0, FSM to IDLE, bit counter and divider cleared.
- Reset asserted mid-frame aborts the frame immediately; TxD returns high on the same edge.
- FSM states: IDLE -> START -> DATA(0..7) -> PARITY -> STOP -> IDLE.
- IDLE:
  - TxD=1, TxD_busy=0.
  - TxD_start=1 at an edge: latch TxD_data into the shift register, compute parity = ~^TxD_data, clear the divider, go to START.
  - TxD_busy and TxD=0 are visible from the next cycle (1-cycle latency).
- Each of START, DATA(n), PARITY and STOP holds TxD constant for exactly BIT_CYCLES clocks, then advances.
  - START drives 0.
  - DATA(n) drives latched bit n, n = 0..7, LSB first.
  - PARITY drives the odd-parity bit: data ones plus parity bit is odd; all-zero byte gives parity 1.
  - STOP drives 1.
- Frame length: exactly 11*BIT_CYCLES clocks from TxD falling to TxD_busy falling.
- TxD_busy is high for every cycle of START through STOP. It drops the cycle after STOP completes, and the FSM is then in IDLE.
- TxD_start while TxD_busy=1 is ignored: no queuing, and the in-flight byte is unaffected.
- Back-to-back: TxD_start asserted in the first cycle TxD_busy=0 is accepted. The next start bit follows the stop bit with no extra idle gap.
- TxD_data changes after the accepting cycle do not affect the frame.
- TxD is a registered output (glitch-free).
- Divider: counts 0..BIT_CYCLES-1; wraps and advances the state on terminal count.

Optional Feature:
ASYNC_TX_TWO_STOP_EN
- Defined: STOP lasts 2*BIT_CYCLES; frame is 12*BIT_CYCLES clocks; TxD_busy is held through both stop bits.
- Undefined (default): one stop bit; frame is 11*BIT_CYCLES clocks.

Test Plan:
- Reset: rst=1 for 1 cycle, then 0 -> TxD=1, TxD_busy=0; no activity without TxD_start.
- Send 0xA5 -> sampling at mid-bit (1.5*BIT_CYCLES after the TxD falling edge, then every BIT_CYCLES) yields data bits 1,0,1,0,0,1,0,1, parity=1, stop=1; TxD_busy high for 11*2604 clocks.
- Send 0x00 -> parity bit 1. Send 0xFF -> parity bit 1. Send 0x01 -> parity bit 0.
- 44 random bytes, each TxD_start followed by 33333 idle clocks -> decoded byte equals sent byte, and parity equals ~^byte for every frame.
- Pulse TxD_start with 0x3C mid-frame while busy -> ignored; the current byte completes unchanged and 0x3C is never sent.
- Assert rst during DATA(3) -> TxD=1 and TxD_busy=0 on the next edge. A following TxD_start with 0x55 sends a clean full frame.
